// File: rtl/common_pkg.sv
// Shared AXI-lite response codes and the FSM state types
// used by the register sink.
package common_pkg;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axil_resp_t AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_AW,
    W_W,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_e;

endpackage

// File: rtl/if_axi_lite.sv
// AXI-lite bundle; the sink modport is the responder side,
// the source modport is the host side.
interface if_axi_lite #(
  parameter int A_BITS = 32
);

  logic              awvalid;
  logic              awready;
  logic [A_BITS-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [A_BITS-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;

  modport sink (
    input  awvalid, awaddr, wvalid, wdata, wstrb,
    input  bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp
  );

  modport source (
    output awvalid, awaddr, wvalid, wdata, wstrb,
    output bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi_lite_reg_sink.sv
// AXI-lite responder exposing a bank of 32-bit RW/RO registers
// with a one-cycle write pulse per register.
module axi_lite_reg_sink
  import common_pkg::*;
#(
  parameter int                  A_BITS   = 32,
  parameter int                  NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  if_axi_lite.sink                 i_axi,
  output logic [NUM_REGS*32-1:0]   o_reg,
  input  logic [NUM_REGS*32-1:0]   i_ro,
  output logic [NUM_REGS-1:0]      o_wr_pls
);

  localparam int IW = $clog2(NUM_REGS);

  typedef struct packed {
    logic          hit;
    logic [IW-1:0] idx;
  } dec_t;

  // Any address bit above the index field marks the access unmapped.
  function automatic dec_t decode(input logic [A_BITS-1:0] a);
    dec_t d;
    d.idx = a[2 +: IW];
    d.hit = ((a >> (2 + IW)) == '0);
    return d;
  endfunction

  w_state_e                    w_q;
  logic [A_BITS-1:0]           awaddr_q;
  logic [31:0]                 wdata_q;
  logic [3:0]                  wstrb_q;
  logic [NUM_REGS-1:0][31:0]   reg_q;
  logic [NUM_REGS-1:0]         pls_q;
  axil_resp_t                  bresp_q;

  r_state_e                    r_q;
  logic [31:0]                 rdata_q;
  axil_resp_t                  rresp_q;

  logic [NUM_REGS-1:0][31:0]   ro_w;
  logic                        aw_held;
  logic                        w_held;
  logic                        bvalid;
  logic                        rvalid;
  logic                        aw_hs;
  logic                        w_hs;
  logic                        ar_hs;
  logic                        commit;
  logic [A_BITS-1:0]           wr_addr_d;
  logic [31:0]                 wr_data_d;
  logic [3:0]                  wr_strb_d;
  dec_t                        wdec;
  dec_t                        rdec;
  logic                        wok;
  logic [31:0]                 rd_val;

  assign ro_w    = i_ro;
  assign aw_held = (w_q == W_AW);
  assign w_held  = (w_q == W_W);
  assign bvalid  = (w_q == W_RESP);
  assign rvalid  = (r_q == R_RESP);

  assign i_axi.awready = i_rst & ~aw_held & ~bvalid;
  assign i_axi.wready  = i_rst & ~w_held & ~bvalid;
  assign i_axi.arready = i_rst & ~rvalid;
  assign i_axi.bvalid  = bvalid;
  assign i_axi.bresp   = bresp_q;
  assign i_axi.rvalid  = rvalid;
  assign i_axi.rdata   = rdata_q;
  assign i_axi.rresp   = rresp_q;

  assign aw_hs = i_axi.awvalid & i_axi.awready;
  assign w_hs  = i_axi.wvalid & i_axi.wready;
  assign ar_hs = i_axi.arvalid & i_axi.arready;

  // Commit on the edge where the later of AW/W lands.
  assign commit    = (aw_hs | aw_held) & (w_hs | w_held);
  assign wr_addr_d = aw_hs ? i_axi.awaddr : awaddr_q;
  assign wr_data_d = w_hs ? i_axi.wdata : wdata_q;
  assign wr_strb_d = w_hs ? i_axi.wstrb : wstrb_q;
  assign wdec      = decode(wr_addr_d);
  assign wok       = wdec.hit & ~RO_MASK[wdec.idx];

  assign rdec   = decode(i_axi.araddr);
  assign rd_val = RO_MASK[rdec.idx] ? ro_w[rdec.idx]
                                    : reg_q[rdec.idx];

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      w_q      <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      reg_q    <= '0;
      pls_q    <= '0;
      bresp_q  <= AXI_RESP_OKAY;
    end else begin
      pls_q <= '0;
      priority case (1'b1)
        commit: begin
          w_q     <= W_RESP;
          bresp_q <= wok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
          if (wok) begin
            pls_q[wdec.idx] <= 1'b1;
            for (int b = 0; b < 4; b++) begin
              if (wr_strb_d[b]) begin
                reg_q[wdec.idx][b*8 +: 8] <= wr_data_d[b*8 +: 8];
              end
            end
          end
        end
        aw_hs: begin
          w_q      <= W_AW;
          awaddr_q <= i_axi.awaddr;
        end
        w_hs: begin
          w_q     <= W_W;
          wdata_q <= i_axi.wdata;
          wstrb_q <= i_axi.wstrb;
        end
        (bvalid & i_axi.bready): begin
          w_q <= W_IDLE;
        end
        default: ;
      endcase
    end
  end

  // reg_q is sampled before this edge's commit lands.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_q     <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= AXI_RESP_OKAY;
    end else begin
      priority case (1'b1)
        ar_hs: begin
          r_q     <= R_RESP;
          rdata_q <= rdec.hit ? rd_val : 32'h0;
          rresp_q <= rdec.hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        end
        (rvalid & i_axi.rready): begin
          r_q <= R_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign o_reg    = reg_q;
  assign o_wr_pls = pls_q;

endmodule

// File: tb/tb_axi_lite_reg_sink.sv
// Directed bench for axi_lite_reg_sink: pokes, peeks,
// split AW/W, RO/unmapped errors, stalls and mid-response reset.
module tb_axi_lite_reg_sink;

  logic         clk;
  logic         rst;
  logic [511:0] o_reg;
  logic [511:0] i_ro;
  logic [15:0]  o_wr_pls;

  int tests;
  int fails;

  if_axi_lite #(.A_BITS(32)) axi ();

  axi_lite_reg_sink #(
    .A_BITS   (32),
    .NUM_REGS (16),
    .RO_MASK  (16'h0001)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_axi    (axi),
    .o_reg    (o_reg),
    .i_ro     (i_ro),
    .o_wr_pls (o_wr_pls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input string tag,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  s,
                      input logic [1:0]  exp_resp,
                      input logic [15:0] exp_pls);
    @(negedge clk);
    chk({tag, "_awready"}, 32'(axi.awready), 32'd1);
    chk({tag, "_wready"}, 32'(axi.wready), 32'd1);
    axi.awvalid = 1'b1;
    axi.awaddr  = a;
    axi.wvalid  = 1'b1;
    axi.wdata   = d;
    axi.wstrb   = s;
    @(negedge clk);
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    chk({tag, "_bvalid"}, 32'(axi.bvalid), 32'd1);
    chk({tag, "_bresp"}, 32'(axi.bresp), 32'(exp_resp));
    chk({tag, "_pls"}, 32'(o_wr_pls), 32'(exp_pls));
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    chk({tag, "_bvalid_clr"}, 32'(axi.bvalid), 32'd0);
    chk({tag, "_pls_clr"}, 32'(o_wr_pls), 32'd0);
  endtask

  task automatic peek(input string tag,
                      input logic [31:0] a,
                      input logic [31:0] exp_data,
                      input logic [1:0]  exp_resp);
    @(negedge clk);
    chk({tag, "_arready"}, 32'(axi.arready), 32'd1);
    axi.arvalid = 1'b1;
    axi.araddr  = a;
    @(negedge clk);
    axi.arvalid = 1'b0;
    chk({tag, "_rvalid"}, 32'(axi.rvalid), 32'd1);
    chk({tag, "_rdata"}, axi.rdata, exp_data);
    chk({tag, "_rresp"}, 32'(axi.rresp), 32'(exp_resp));
    axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
    chk({tag, "_rvalid_clr"}, 32'(axi.rvalid), 32'd0);
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    rst         = 1'b0;
    i_ro        = '0;
    i_ro[31:0]  = 32'hCAFE0001;
    i_ro[95:64] = 32'h5555AAAA;
    axi.awvalid = 1'b0;
    axi.awaddr  = '0;
    axi.wvalid  = 1'b0;
    axi.wdata   = '0;
    axi.wstrb   = '0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.araddr  = '0;
    axi.rready  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_oreg_lo", o_reg[31:0], 32'h0);
    chk("rst_oreg_r2", o_reg[95:64], 32'h0);
    chk("rst_pls", 32'(o_wr_pls), 32'h0);
    chk("rst_bvalid", 32'(axi.bvalid), 32'd0);
    chk("rst_rvalid", 32'(axi.rvalid), 32'd0);
    chk("rst_awready", 32'(axi.awready), 32'd0);
    chk("rst_wready", 32'(axi.wready), 32'd0);
    chk("rst_arready", 32'(axi.arready), 32'd0);
    rst = 1'b1;

    poke("poke_r2", 32'h8, 32'hDEADBEEF, 4'hF, 2'b00, 16'h0004);
    chk("r2_val", o_reg[95:64], 32'hDEADBEEF);
    peek("peek_r2", 32'h8, 32'hDEADBEEF, 2'b00);
    peek("peek_r2_lowbits", 32'hB, 32'hDEADBEEF, 2'b00);

    poke("preload_r1", 32'h4, 32'hFFFFFFFF, 4'hF, 2'b00, 16'h0002);

    // W three cycles ahead of AW
    @(negedge clk);
    axi.wvalid = 1'b1;
    axi.wdata  = 32'h12345678;
    axi.wstrb  = 4'b0011;
    @(negedge clk);
    axi.wvalid = 1'b0;
    chk("wfirst_wready", 32'(axi.wready), 32'd0);
    chk("wfirst_awready", 32'(axi.awready), 32'd1);
    chk("wfirst_bvalid", 32'(axi.bvalid), 32'd0);
    repeat (2) @(negedge clk);
    chk("wfirst_r1_hold", o_reg[63:32], 32'hFFFFFFFF);
    axi.awvalid = 1'b1;
    axi.awaddr  = 32'h4;
    @(negedge clk);
    axi.awvalid = 1'b0;
    chk("wfirst_bvalid_set", 32'(axi.bvalid), 32'd1);
    chk("wfirst_bresp", 32'(axi.bresp), 32'd0);
    chk("wfirst_r1", o_reg[63:32], 32'hFFFF5678);
    chk("wfirst_pls", 32'(o_wr_pls), 32'h0002);
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    chk("wfirst_bclr", 32'(axi.bvalid), 32'd0);

    poke("strb0_r2", 32'h8, 32'h0BADF00D, 4'h0, 2'b00, 16'h0004);
    chk("strb0_r2_val", o_reg[95:64], 32'hDEADBEEF);

    poke("ro_r0", 32'h0, 32'h11111111, 4'hF, 2'b10, 16'h0000);
    chk("ro_r0_val", o_reg[31:0], 32'h0);
    peek("ro_peek_r0", 32'h0, 32'hCAFE0001, 2'b00);

    poke("unmap_w", 32'h40, 32'h22222222, 4'hF, 2'b10, 16'h0000);
    chk("unmap_r0", o_reg[31:0], 32'h0);
    peek("unmap_r", 32'h40, 32'h0, 2'b10);

    // read and commit to reg 2 on the same edge
    @(negedge clk);
    axi.awvalid = 1'b1;
    axi.awaddr  = 32'h8;
    axi.wvalid  = 1'b1;
    axi.wdata   = 32'h11112222;
    axi.wstrb   = 4'hF;
    axi.arvalid = 1'b1;
    axi.araddr  = 32'h8;
    @(negedge clk);
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.arvalid = 1'b0;
    chk("same_rdata", axi.rdata, 32'hDEADBEEF);
    chk("same_r2", o_reg[95:64], 32'h11112222);
    axi.bready = 1'b1;
    axi.rready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    axi.rready = 1'b0;

    // stalled responses, then reset mid-response
    @(negedge clk);
    axi.awvalid = 1'b1;
    axi.awaddr  = 32'hC;
    axi.wvalid  = 1'b1;
    axi.wdata   = 32'hA5A50003;
    axi.wstrb   = 4'hF;
    axi.arvalid = 1'b1;
    axi.araddr  = 32'h8;
    @(negedge clk);
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.arvalid = 1'b0;
    chk("stall_r3", o_reg[127:96], 32'hA5A50003);
    for (int i = 0; i < 5; i++) begin
      chk("stall_bvalid", 32'(axi.bvalid), 32'd1);
      chk("stall_rvalid", 32'(axi.rvalid), 32'd1);
      chk("stall_rdata", axi.rdata, 32'h11112222);
      chk("stall_bresp", 32'(axi.bresp), 32'd0);
      chk("stall_rdy", {29'd0, axi.awready, axi.wready, axi.arready},
          32'd0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_bvalid", 32'(axi.bvalid), 32'd0);
    chk("mrst_rvalid", 32'(axi.rvalid), 32'd0);
    chk("mrst_r2", o_reg[95:64], 32'h0);
    chk("mrst_r3", o_reg[127:96], 32'h0);
    chk("mrst_r1", o_reg[63:32], 32'h0);
    rst = 1'b1;
    peek("post_rst_r3", 32'hC, 32'h0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
